// File: rtl/multi_pulse_sync_pkg.sv
// multi_pulse_sync_pkg: shared edge-mode codes and channel state encoding
package multi_pulse_sync_pkg;
  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;
  localparam logic [1:0] EDGE_OFF  = 2'b11;
  typedef enum logic {ST_IDLE, ST_HOLD} state_t;
endpackage

// File: rtl/multi_pulse_sync_if.sv
// multi_pulse_sync_if: async inputs, shared config and per-channel outputs of the pulse synchroniser
//   in          async input levels/pulses, one bit per channel
//   edge_mode   00 rise, 01 fall, 10 both, 11 disabled
//   n_min_width extra stable cycles before the filtered level changes
//   n_holdoff   dead-time cycles after an accepted event
//   out         one-cycle pulse per accepted event
//   level       deglitched synchronised level
//   missed      one-cycle pulse per edge rejected during holdoff
interface multi_pulse_sync_if #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 8
);
  logic [N_CH-1:0]  in;
  logic [1:0]       edge_mode;
  logic [CNT_W-1:0] n_min_width;
  logic [CNT_W-1:0] n_holdoff;
  logic [N_CH-1:0]  out;
  logic [N_CH-1:0]  level;
  logic [N_CH-1:0]  missed;
  modport master (output in, edge_mode, n_min_width, n_holdoff, input out, level, missed);
  modport slave  (input in, edge_mode, n_min_width, n_holdoff, output out, level, missed);
endinterface

// File: rtl/multi_pulse_sync_channel.sv
// pulse_sync_channel: one channel of sync chain, deglitch filter, edge qualifier and holdoff FSM
//   clk, rst_n      destination clock, async active-low reset
//   in_i            asynchronous input
//   edge_mode_i     edge selection (rise/fall/both/off)
//   n_min_width_i   deglitch width, n_holdoff_i dead time
//   out_o, level_o, missed_o  event pulse, filtered level, rejected-event pulse
module pulse_sync_channel
  import multi_pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_i,
  input  logic [1:0]       edge_mode_i,
  input  logic [CNT_W-1:0] n_min_width_i,
  input  logic [CNT_W-1:0] n_holdoff_i,
  output logic             out_o,
  output logic             level_o,
  output logic             missed_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   flt_q, flt_d, flt_dly_q;
  logic [CNT_W-1:0]       fc_q, fc_d, hc_q, hc_d;
  logic                   out_q, out_d, missed_q, missed_d;
  logic                   rise, fall, ev;
  state_t                 state_q, state_d;

  assign s = sync_q[SYNC_STAGES-1];

  // >= rather than == so a width lowered mid-count still terminates instead of wrapping
  always_comb begin
    flt_d = flt_q;
    fc_d  = '0;
    if (s != flt_q) begin
      if (fc_q >= n_min_width_i) flt_d = s;
      else fc_d = fc_q + CNT_W'(1);
    end
  end

  assign rise = flt_q & ~flt_dly_q;
  assign fall = ~flt_q & flt_dly_q;
  assign ev   = edge_mode_i == EDGE_RISE ? rise :
                edge_mode_i == EDGE_FALL ? fall :
                edge_mode_i == EDGE_BOTH ? (rise | fall) : 1'b0;

  // holdoff length is latched into hc at acceptance, so later config changes only affect the next event
  always_comb begin
    state_d  = state_q;
    hc_d     = hc_q;
    out_d    = 1'b0;
    missed_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (ev) begin
        out_d   = 1'b1;
        hc_d    = n_holdoff_i;
        state_d = (n_holdoff_i != '0) ? ST_HOLD : ST_IDLE;
      end
    end else begin
      hc_d     = (hc_q != '0) ? hc_q - CNT_W'(1) : '0;
      missed_d = ev;
      state_d  = (hc_q <= CNT_W'(1)) ? ST_IDLE : ST_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      flt_q     <= 1'b0;
      flt_dly_q <= 1'b0;
      fc_q      <= '0;
      hc_q      <= '0;
      out_q     <= 1'b0;
      missed_q  <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], in_i};
      flt_q     <= flt_d;
      flt_dly_q <= flt_q;
      fc_q      <= fc_d;
      hc_q      <= hc_d;
      out_q     <= out_d;
      missed_q  <= missed_d;
      state_q   <= state_d;
    end
  end

  assign out_o    = out_q;
  assign missed_o = missed_q;
  assign level_o  = flt_q;
endmodule

// File: rtl/multi_pulse_sync.sv
// multi_pulse_sync: N-channel synchroniser/deglitcher/edge-qualifier with holdoff
//   clk, rst_n  destination clock, async active-low reset
//   bus         slave side of multi_pulse_sync_if (inputs, shared config, per-channel outputs)
module multi_pulse_sync
  import multi_pulse_sync_pkg::*;
#(
  parameter int N_CH        = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input logic                clk,
  input logic                rst_n,
  multi_pulse_sync_if.slave  bus
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_sync_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_i          (bus.in[i]),
      .edge_mode_i   (bus.edge_mode),
      .n_min_width_i (bus.n_min_width),
      .n_holdoff_i   (bus.n_holdoff),
      .out_o         (bus.out[i]),
      .level_o       (bus.level[i]),
      .missed_o      (bus.missed[i])
    );
  end
endmodule

// File: doc/multi_pulse_sync.md
Name: multi_pulse_sync

Overview:
- N-channel synchroniser for asynchronous external pulses and levels into the `clk` domain.
- Each channel has:
  - a parametrised synchroniser chain;
  - a runtime-programmable minimum-width deglitch filter;
  - edge selection: rise, fall, both or disabled;
  - a runtime-programmable holdoff (dead time) after each accepted event.
- Outputs are one-cycle event pulses, filtered levels, and one-cycle flags for events rejected during holdoff.
- Sits between front-panel/trigger inputs and the trigger/control logic.

Parameters:
- N_CH, 8: number of independent channels.
- SYNC_STAGES, 2: synchroniser flops per channel; legal range is 2 or more.
- CNT_W, 8: width of the deglitch and holdoff counters and their config inputs.

Ports:
- clk  in  1  destination clock; all logic is in this domain.
- rst_n  in  1  asynchronous, active-low reset.
- in  in  N_CH  asynchronous input levels/pulses, one bit per channel.
- edge_mode  in  2  shared across channels; 00 = rise, 01 = fall, 10 = both, 11 = disabled.
- n_min_width  in  CNT_W  extra stable cycles required before the filtered level changes.
- n_holdoff  in  CNT_W  dead-time cycles after an accepted event.
- out  out  N_CH  one-cycle pulse per accepted event.
- level  out  N_CH  deglitched, synchronised level.
- missed  out  N_CH  one-cycle pulse per qualified edge rejected during holdoff.

Behaviour:
- Reset, asynchronous on rst_n low:
  - clears every sync flop, filtered level, counters and state;
  - out, level and missed are 0.
- Reset mid-operation aborts holdoff and pending filtering immediately.
- After reset release, an input already high is seen as a rising edge after normal latency.
- Sync chain: `in[i]` passes through SYNC_STAGES flops; the last stage is `s[i]`.
- Deglitch, per channel, with counter `fc` and filtered level `f`:
  - if s == f: fc <= 0;
  - else if fc == n_min_width: f <= s and fc <= 0;
  - else fc <= fc + 1.
  - With n_min_width = 0, f follows s one clock later.
  - A glitch shorter than n_min_width+1 cycles at s never changes f.
- Edge qualification: `ev` is a combinational function of f versus f_d (f delayed one cycle) and edge_mode.
  - Mode 11 suppresses all events, including missed.
  - edge_mode is sampled live; a change takes effect on the next qualification.
- Per-channel state machine:
  - IDLE, on ev:
    - out <= 1 for exactly one cycle;
    - hc <= n_holdoff;
    - go to HOLD if n_holdoff != 0, else stay in IDLE.
  - HOLD, every cycle: hc <= hc - 1; when hc == 1, go to IDLE.
  - HOLD, on ev: missed <= 1 for one cycle and out stays 0. The holdoff is not restarted.
  - HOLD therefore lasts exactly n_holdoff cycles. An ev arriving on the first IDLE cycle after HOLD is accepted.
  - n_holdoff is captured only at load; changing it mid-HOLD does not affect the current holdoff.
- Latency: out rises on edge SYNC_STAGES + n_min_width + 2, counted from the first clk edge that samples the new input value.
- level = f, registered.
- Minimum event spacing with n_holdoff = 0 is 2 cycles, limited by the f/f_d edge detect.
- Channels are fully independent; simultaneous events on multiple channels each produce their own out pulse in the same cycle.
- Counters never wrap:
  - fc stops at n_min_width;
  - hc stops at 0.

Decomposition:
- Package multi_pulse_sync_pkg holds:
  - edge-mode constants EDGE_RISE = 2'b00, EDGE_FALL = 2'b01, EDGE_BOTH = 2'b10, EDGE_OFF = 2'b11;
  - state encoding ST_IDLE / ST_HOLD.
- One sub-module, pulse_sync_channel, implements a single channel: sync chain, deglitch, edge detect and state machine.
- The top instantiates N_CH copies of pulse_sync_channel via a generate loop, sharing the config inputs.

Test Plan:
- Reset and latency: SYNC_STAGES = 2, n_min_width = 0, edge_mode = 00; drive in[0] high for 20 cycles.
  - out[0] pulses exactly once, for 1 cycle, on edge 4 after the first sampling edge.
  - level[0] rises one cycle earlier.
  - All outputs are 0 during reset.
- Deglitch: n_min_width = 3.
  - 3-cycle high pulse -> no out, level stays 0.
  - 4-cycle pulse -> one out pulse, 3 cycles later than in the n_min_width = 0 case.
- Edge modes on a single 10-cycle high pulse:
  - mode 00 -> 1 pulse at the rise;
  - mode 01 -> 1 pulse at the fall;
  - mode 10 -> 2 pulses;
  - mode 11 -> 0 pulses and 0 missed.
- Holdoff: n_holdoff = 10, mode 10, in toggling every 4 cycles.
  - First edge -> out.
  - Next two edges -> missed pulses.
  - The edge 12 cycles after the first -> out again.
  - n_holdoff changed mid-HOLD -> no effect on the current holdoff.
- Multi-channel: simultaneous rises on channels 0, 3 and 7 -> out = 8'h89 for one cycle; other channels stay 0.
- Reset mid-HOLD: assert rst_n low for 1 cycle with in high.
  - All outputs clear asynchronously.
  - After release, one new out pulse appears at normal latency.
